// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, issues one imem request at a time
// and fills the IF/ID register, honouring stall, redirect and halt.
module fetch_stage #(
    parameter int                  PC_W     = 9,
    parameter int                  INSTR_W  = 32,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP      = 32'h13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               halted
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, addr_q, addr_d, ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d, skid_q, skid_d;
    logic               drop_q, drop_d, req_q, req_d, valid_q, valid_d, halted_q, halted_d;
    logic               out_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        skid_d    = skid_q;
        halted_d  = halted_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = stall ? valid_q : 1'b0;
        instr_d   = stall ? instr_q : NOP;
        case (state_q)
            // req_q=0 in FETCH only right after reset: inherit any response still owed
            FETCH: begin
                drop_d = (req_q ? drop_q : out_q) & ~imem_rvalid;
                if (req_q) state_d = WAIT;
            end
            WAIT: if (imem_rvalid) begin
                if (drop_q) begin
                    drop_d  = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d   = 1'b1;
                    ifid_pc_d = pc_q;
                    instr_d   = imem_rdata;
                    pc_d      = pc_q + PC_W'(4);
                    state_d   = FETCH;
                end else begin
                    skid_d  = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: if (!stall) begin
                valid_d   = 1'b1;
                ifid_pc_d = pc_q;
                instr_d   = skid_q;
                pc_d      = pc_q + PC_W'(4);
                state_d   = FETCH;
            end
            default: ;
        endcase
        if (halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
            valid_d  = 1'b0;
            instr_d  = NOP;
            skid_d   = '0;
            drop_d   = 1'b0;
        end else if (redirect && state_q != HALT) begin
            pc_d    = redirect_pc & ~PC_W'(3);
            valid_d = 1'b0;
            instr_d = NOP;
            skid_d  = '0;
            // a request still in flight must have its response discarded
            if ((state_q == WAIT && !imem_rvalid) || (state_q == FETCH && req_q)) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else begin
                state_d = FETCH;
            end
        end
        req_d  = state_d == FETCH;
        addr_d = req_d ? pc_d : addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            ifid_pc_q <= '0;
            instr_q   <= NOP;
            skid_q    <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            ifid_pc_q <= ifid_pc_d;
            instr_q   <= instr_d;
            skid_q    <= skid_d;
            halted_q  <= halted_d;
        end
    end

    // deliberately not reset: remembers a request still owed by imem across a reset
    always_ff @(posedge clk) out_q <= req_q | (out_q & ~imem_rvalid);

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ifid_valid = valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = instr_q;
    assign halted     = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a program-order
// fetch model and a variable-latency instruction memory returning 0xA0000000|addr.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h13;

    logic        clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, ifid_valid, halted;
    logic [8:0]  imem_addr, ifid_pc;
    logic [31:0] ifid_instr;

    int          tests = 0, fails = 0, loads = 0, pend = 0, lat = 1;
    bit          rnd = 1'b0;
    logic [8:0]  paddr = '0, exp_req = '0, ppc = '0, a = '0;
    logic        pv = 1'b0, phold = 1'b0;
    logic [31:0] pinstr = NOP;
    logic [8:0]  exp_q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one cycle: check outputs against the model, then advance the memory responder
    task automatic step();
        logic [8:0] e;
        phold = stall && !redirect && !halt && reset;
        @(negedge clk);
        if (imem_req) begin
            chk("req_addr", 64'(imem_addr), 64'(exp_req));
            exp_q.push_back(exp_req);
            exp_req = exp_req + 9'd4;
        end
        if (ifid_valid && (!pv || ifid_pc != ppc)) begin
            chk("load_outstanding", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("load_pc", 64'(ifid_pc), 64'(e));
                chk("load_instr", 64'(ifid_instr), 64'(32'hA000_0000 | 32'(e)));
                loads++;
            end
        end
        if (!ifid_valid) chk("bubble_nop", 64'(ifid_instr), 64'(NOP));
        if (phold) chk("stall_hold", 64'({ifid_valid, ifid_pc, ifid_instr}), 64'({pv, ppc, pinstr}));
        pv = ifid_valid;
        ppc = ifid_pc;
        pinstr = ifid_instr;
        imem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = 32'hA000_0000 | 32'(paddr);
            end
        end
        if (imem_req) begin
            pend = rnd ? int'($urandom_range(1, 4)) : lat;
            paddr = imem_addr;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        do begin step(); n++; end while (!imem_req && n < 40);
        chk("req_seen", 64'(imem_req), 64'd1);
        a = imem_addr;
    endtask

    task automatic wait_load();
        int n = 0;
        do begin step(); n++; end while (!ifid_valid && n < 40);
        chk("load_seen", 64'(ifid_valid), 64'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_valid"}, 64'(ifid_valid), 64'd0);
        chk({tag, "_pc"}, 64'(ifid_pc), 64'd0);
        chk({tag, "_instr"}, 64'(ifid_instr), 64'(NOP));
        chk({tag, "_halted"}, 64'(halted), 64'd0);
    endtask

    initial begin
        step();
        imem_rvalid = 1'b1;
        step();
        chk_reset("rst");
        reset = 1'b1;
        lat = 1;
        wait_req();
        chk("first_addr", 64'(a), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            chk("seq_valid", 64'(ifid_valid), 64'd1);
            chk("seq_pc", 64'(ifid_pc), 64'(4 * i));
            chk("seq_instr", 64'(ifid_instr), 64'(32'hA000_0000 | 32'(4 * i)));
            chk("seq_req", 64'(imem_req), 64'd1);
            chk("seq_next_addr", 64'(imem_addr), 64'(4 * (i + 1)));
        end
        step();
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_noreq", 64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        step();
        chk("skid_valid", 64'(ifid_valid), 64'd1);
        chk("skid_pc", 64'(ifid_pc), 64'h00C);
        chk("skid_instr", 64'(ifid_instr), 64'hA000_000C);
        chk("skid_next_req", 64'({imem_req, imem_addr}), 64'({1'b1, 9'h010}));
        lat = 3;
        wait_req();
        step();
        redirect = 1'b1;
        redirect_pc = 9'h043;
        exp_q.delete();
        exp_req = 9'h040;
        step();
        redirect = 1'b0;
        chk("redir_flush", 64'({ifid_valid, ifid_instr}), 64'({1'b0, NOP}));
        wait_req();
        chk("redir_addr", 64'(a), 64'h040);
        chk("redir_noload", 64'(ifid_valid), 64'd0);
        wait_load();
        chk("redir_load_pc", 64'(ifid_pc), 64'h040);
        lat = 1;
        wait_req();
        step();
        redirect = 1'b1;
        redirect_pc = 9'h1FC;
        exp_q.delete();
        exp_req = 9'h1FC;
        step();
        redirect = 1'b0;
        chk("wrap_top", 64'({imem_req, imem_addr}), 64'({1'b1, 9'h1FC}));
        wait_req();
        chk("wrap_zero", 64'(a), 64'h000);
        rnd = 1'b1;
        repeat (300) begin
            stall = $urandom_range(0, 9) < 3;
            step();
        end
        stall = 1'b0;
        rnd = 1'b0;
        repeat (12) step();
        chk("rand_loads", 64'(loads >= 30), 64'd1);
        lat = 3;
        wait_req();
        step();
        redirect = 1'b1;
        redirect_pc = 9'h080;
        exp_q.delete();
        exp_req = 9'h080;
        step();
        redirect = 1'b0;
        wait_req();
        chk("pre_reset_addr", 64'(a), 64'h080);
        step();
        #2 reset = 1'b0;
        #1 chk_reset("async_rst");
        exp_q.delete();
        exp_req = '0;
        step();
        reset = 1'b1;
        wait_req();
        chk("restart_addr", 64'(a), 64'd0);
        wait_load();
        chk("restart_pc", 64'(ifid_pc), 64'd0);
        chk("restart_instr", 64'(ifid_instr), 64'hA000_0000);
        wait_req();
        step();
        halt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 9'h100;
        exp_q.delete();
        step();
        halt = 1'b0;
        redirect = 1'b0;
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_flush", 64'({ifid_valid, ifid_instr}), 64'({1'b0, NOP}));
        repeat (10) begin
            step();
            chk("halt_noreq", 64'(imem_req), 64'd0);
            chk("halt_stays", 64'({halted, ifid_valid}), 64'({1'b1, 1'b0}));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
